// File: rtl/seq_alu.sv
// seq_alu: one operation at a time behind a valid/ready handshake.
// Single-cycle ops retire one cycle after acceptance. MPY is an unsigned
// radix-2 shift-add that takes WIDTH iterations and returns a 2*WIDTH product.
module seq_alu #(
    parameter  int WIDTH = 32,
    parameter  int OPW   = 5,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    // Opcode map shared with decode/issue.
    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_MPY = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA = OPW'(7);
    localparam logic [OPW-1:0] OP_SRL = OPW'(8);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t state;

    // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
    logic [WIDTH-1:0]   mplr;
    logic [SHW-1:0]     cnt;

    // Single-cycle datapath.
    logic [WIDTH:0]            sum, dif;
    logic                      big_sh;
    logic [SHW-1:0]            sh;
    logic signed [WIDTH-1:0]   sra_res;
    logic [WIDTH-1:0]          alu_res;
    logic                      alu_c, alu_v, alu_err;

    assign in_ready = (state == IDLE) && rst_n;

    // Subtraction as a + ~b + 1 so the carry out is NOT borrow.
    assign sum     = {1'b0, data_a} + {1'b0, data_b};
    assign dif     = {1'b0, data_a} + {1'b0, ~data_b} + {{WIDTH{1'b0}}, 1'b1};
    // Any bit above the shift field means the amount is >= WIDTH.
    assign big_sh  = |data_b[WIDTH-1:SHW];
    assign sh      = data_b[SHW-1:0];
    // Kept separate so the arithmetic shift stays signed.
    assign sra_res = $signed(data_a) >>> sh;
    assign acc_nxt = acc + (mplr[0] ? mcand : '0);

    // Result and carry/overflow for the single-cycle ops.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = dif[WIDTH];
                alu_v   = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                          (dif[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_MPY: alu_res = '0;
            OP_AND: alu_res = data_a & data_b;
            OP_OR:  alu_res = data_a | data_b;
            OP_XOR: alu_res = data_a ^ data_b;
            OP_SHL: alu_res = big_sh ? '0 : (data_a << sh);
            OP_SRA: alu_res = big_sh ? {WIDTH{data_a[WIDTH-1]}} : sra_res;
            OP_SRL: alu_res = big_sh ? '0 : (data_a >> sh);
            default: alu_err = 1'b1;
        endcase
    end

    // Control FSM with registered result, flags and handshake state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            data_out  <= '0;
            data_hi   <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
            mcand     <= '0;
            mplr      <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (flush) begin
            // Abort wins over accept/retire; data registers keep their value.
            state     <= IDLE;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (opcode == OP_MPY) begin
                        mcand <= {{WIDTH{1'b0}}, data_a};
                        mplr  <= data_b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MUL;
                    end else begin
                        data_out  <= alu_res;
                        data_hi   <= '0;
                        flag_z    <= (alu_res == '0);
                        flag_n    <= alu_res[WIDTH-1];
                        flag_c    <= alu_c;
                        flag_v    <= alu_v;
                        err       <= alu_err;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                MUL: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    // Last iteration writes the product straight to the outputs.
                    if (cnt == SHW'(WIDTH - 1)) begin
                        data_out  <= acc_nxt[WIDTH-1:0];
                        data_hi   <= acc_nxt[2*WIDTH-1:WIDTH];
                        flag_z    <= (acc_nxt[WIDTH-1:0] == '0);
                        flag_n    <= acc_nxt[WIDTH-1];
                        flag_c    <= 1'b0;
                        flag_v    <= |acc_nxt[2*WIDTH-1:WIDTH];
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: transaction-level reference model plus per-cycle compare,
// directed literal checks, randomized traffic, and a WIDTH=16 multiply check.
module tb_seq_alu;

    localparam int W   = 32;
    localparam int W16 = 16;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MPY = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_SHL = 5'd6;
    localparam logic [4:0] OP_SRA = 5'd7;
    localparam logic [4:0] OP_SRL = 5'd8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (WIDTH=32)
    logic         rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [4:0]   opcode = '0;
    logic [W-1:0] data_a = '0, data_b = '0;
    logic         in_ready, out_valid, flag_z, flag_n, flag_c, flag_v, err;
    logic [W-1:0] data_out, data_hi;

    seq_alu #(.WIDTH(W), .OPW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .data_a(data_a), .data_b(data_b), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .data_hi(data_hi), .flag_z(flag_z),
        .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .err(err)
    );

    // Second DUT at WIDTH=16
    logic           r16_n = 1'b0, fl16 = 1'b0, iv16 = 1'b0, or16 = 1'b1;
    logic [4:0]     op16 = '0;
    logic [W16-1:0] a16 = '0, b16 = '0;
    logic           ir16, ov16, z16, n16, c16, v16, e16;
    logic [W16-1:0] lo16, hi16;

    seq_alu #(.WIDTH(W16), .OPW(5)) dut16 (
        .clk(clk), .rst_n(r16_n), .flush(fl16), .in_valid(iv16), .in_ready(ir16),
        .opcode(op16), .data_a(a16), .data_b(b16), .out_valid(ov16),
        .out_ready(or16), .data_out(lo16), .data_hi(hi16), .flag_z(z16),
        .flag_n(n16), .flag_c(c16), .flag_v(v16), .err(e16)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic z, n, c, v, e;
    } res_t;

    // Reference result from the arithmetic rules, using 64-bit integers.
    function automatic res_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        longint unsigned ua, ub, p;
        longint sa, sb, s, smax, smin;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        r = '0;
        case (op)
            OP_ADD: begin
                p = ua + ub; r.lo = p[W-1:0]; r.c = p[W];
                s = sa + sb; r.v = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                p = ua - ub; r.lo = p[W-1:0]; r.c = (ua >= ub);
                s = sa - sb; r.v = (s > smax) || (s < smin);
            end
            OP_MPY: begin
                p = ua * ub; r.lo = p[W-1:0]; r.hi = p[2*W-1:W]; r.v = (r.hi != 0);
            end
            OP_AND: r.lo = a & b;
            OP_OR:  r.lo = a | b;
            OP_XOR: r.lo = a ^ b;
            OP_SHL: begin p = (ub >= W) ? 64'd0 : (ua << ub); r.lo = p[W-1:0]; end
            OP_SRL: r.lo = (ub >= W) ? '0 : W'(ua >> ub);
            OP_SRA: begin s = (ub >= W) ? (sa < 0 ? -64'sd1 : 64'sd0) : (sa >>> ub); r.lo = s[W-1:0]; end
            default: r.e = 1'b1;
        endcase
        r.z = (r.lo == '0);
        r.n = r.lo[W-1];
        return r;
    endfunction

    // Transaction model: idle / busy multiplying (countdown) / holding a result.
    bit   m_busy = 0, m_valid = 0;
    int   m_cnt = 0;
    res_t m_res = '0, m_pend = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 0; m_valid <= 0; m_cnt <= 0; m_res <= '0;
        end else if (flush) begin
            m_busy <= 0; m_valid <= 0; m_res.e <= 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin m_busy <= 0; m_valid <= 1; m_res <= m_pend; end
            m_cnt <= m_cnt - 1;
        end else if (in_valid) begin
            if (opcode == OP_MPY) begin
                m_busy <= 1; m_cnt <= W; m_pend <= model(opcode, data_a, data_b);
            end else begin
                m_valid <= 1; m_res <= model(opcode, data_a, data_b);
            end
        end
    end

    // Per-cycle compare, sampled on the falling edge.
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  in_ready,  rst_n && !m_busy && !m_valid);
            chk("out_valid", out_valid, m_valid);
            chk("data_out",  data_out,  m_res.lo);
            chk("data_hi",   data_hi,   m_res.hi);
            chk("flags_zncv", {flag_z, flag_n, flag_c, flag_v}, {m_res.z, m_res.n, m_res.c, m_res.v});
            chk("err",       err,       m_res.e);
        end
    end

    // Issue one op, wait for the result; optionally leave it held (hold=1).
    task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output int lat);
        int g;
        @(negedge clk); #1;
        in_valid = 1; opcode = op; data_a = a; data_b = b; out_ready = !hold; flush = 0;
        g = 0;
        while (!in_ready && g < 100) begin @(negedge clk); #1; g++; end
        if (g >= 100) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 0; opcode = 5'($urandom); data_a = $urandom; data_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (lat >= 200) chk("result_timeout", 1, 0);
        lo = data_out; hi = data_hi;
        if (!hold) begin @(posedge clk); #1; end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {W{1'b1}};
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] lo, hi;
        int lat;

        // Reset
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        @(negedge clk); #1; rst_n = 1;

        // Pin the model against hand-computed values
        chk("model_add", model(OP_ADD, 32'h7FFFFFFF, 32'd1).lo, 64'h80000000);
        chk("model_mpy_hi", model(OP_MPY, 32'hFFFFFFFF, 32'd2).hi, 64'd1);
        chk("model_sra", model(OP_SRA, -32'sd200, 32'd255).lo, 64'hFFFFFFFF);

        // ADD / SUB
        do_op(OP_ADD, 32'd1, 32'd5, 0, lo, hi, lat);
        chk("add1_lat", lat, 1);
        chk("add1_res", lo, 6);
        chk("add1_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
        do_op(OP_ADD, 32'h7FFFFFFF, 32'd1, 0, lo, hi, lat);
        chk("add_ovf_res", lo, 64'h80000000);
        chk("add_ovf_flags", {flag_n, flag_c, flag_v}, 3'b101);
        do_op(OP_SUB, 32'd8, 32'd3, 0, lo, hi, lat);
        chk("sub_res", lo, 5);
        chk("sub_c", flag_c, 1);
        do_op(OP_SUB, 32'd0, 32'd3, 0, lo, hi, lat);
        chk("sub_neg_res", lo, 64'hFFFFFFFD);
        chk("sub_neg_nc", {flag_n, flag_c}, 2'b10);
        do_op(OP_SUB, 32'd5, 32'd5, 0, lo, hi, lat);
        chk("sub_zero_z", flag_z, 1);

        // MPY
        do_op(OP_MPY, 32'd8, 32'd7, 0, lo, hi, lat);
        chk("mpy_lat", lat, 33);
        chk("mpy_lo", lo, 56);
        chk("mpy_hi", hi, 0);
        do_op(OP_MPY, 32'hFFFFFFFF, 32'd2, 0, lo, hi, lat);
        chk("mpy2_lo", lo, 64'hFFFFFFFE);
        chk("mpy2_hi", hi, 1);
        chk("mpy2_v", flag_v, 1);

        // Shifts
        do_op(OP_SHL, 32'd7, 32'd3, 0, lo, hi, lat);       chk("shl", lo, 56);
        do_op(OP_SRA, -32'sd200, 32'd2, 0, lo, hi, lat);   chk("sra", lo, 64'hFFFFFFCE);
        do_op(OP_SRA, -32'sd200, 32'd255, 0, lo, hi, lat); chk("sra_big", lo, 64'hFFFFFFFF);
        do_op(OP_SRL, -32'sd200, 32'd2, 0, lo, hi, lat);   chk("srl", lo, 64'h3FFFFFCE);
        do_op(OP_SHL, 32'd1, 32'd32, 0, lo, hi, lat);      chk("shl_big", lo, 0);

        // Illegal opcode
        do_op(5'h1F, 32'd9, 32'd9, 0, lo, hi, lat);
        chk("ill_lat", lat, 1);
        chk("ill_res", lo, 0);
        chk("ill_err", err, 1);
        chk("ill_z", flag_z, 1);

        // Backpressure
        do_op(OP_ADD, 32'd20, 32'd22, 1, lo, hi, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", {out_valid, in_ready, data_out}, {1'b1, 1'b0, 32'd42});
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("bp_retire_valid", out_valid, 0);
        chk("bp_retire_ready", in_ready, 1);

        // Flush mid-multiply
        @(negedge clk); #1;
        in_valid = 1; opcode = OP_MPY; data_a = 32'd123; data_b = 32'd456;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1; flush = 1;
        @(posedge clk); #1; flush = 0;
        chk("flush_idle", in_ready, 1);
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            chk("flush_no_valid", out_valid, 0);
        end

        // Reset while holding a result
        do_op(OP_ADD, 32'd3, 32'd4, 1, lo, hi, lat);
        @(negedge clk); #1; rst_n = 0;
        @(posedge clk); #1;
        chk("rst_done_valid", out_valid, 0);
        chk("rst_done_data", data_out, 0);
        @(negedge clk); #1; rst_n = 1; out_ready = 1;

        // WIDTH=16 multiply
        @(negedge clk); #1; r16_n = 1;
        @(negedge clk); #1; iv16 = 1; op16 = OP_MPY; a16 = 16'hFFFF; b16 = 16'hFFFF; or16 = 0;
        @(posedge clk); #1; iv16 = 0; a16 = 16'h1234; b16 = 16'h5678;
        lat = 1;
        while (!ov16 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("w16_lat", lat, 17);
        chk("w16_lo", lo16, 16'h0001);
        chk("w16_hi", hi16, 16'hFFFE);
        chk("w16_v", v16, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            rst_n     = ($urandom_range(0, 299) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 11))
                0: opcode = OP_ADD;  1: opcode = OP_SUB;  2: opcode = OP_MPY;
                3: opcode = OP_AND;  4: opcode = OP_OR;   5: opcode = OP_XOR;
                6: opcode = OP_SHL;  7: opcode = OP_SRA;  8: opcode = OP_SRL;
                9: opcode = OP_ADD;  10: opcode = OP_SUB;
                default: opcode = 5'($urandom_range(9, 31));
            endcase
            data_a = rand_operand();
            data_b = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 40)) : rand_operand();
        end
        @(negedge clk);
        #1;
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
